// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing: load-use stalls, branch flushes,
// data-memory wait states with timeout, and EX operand forwarding.
module pipe_hazard_ctrl #(
  parameter int DM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_writeReg,
  input  logic        ex_RegWrite,
  input  logic        ex_MemToReg,
  input  logic [4:0]  mem_writeReg,
  input  logic        mem_RegWrite,
  input  logic        mem_MemToReg,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [4:0]  wb_writeReg,
  input  logic        wb_RegWrite,
  input  logic        branch_taken,
  input  logic        dm_ready,
  output logic        dm_req,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        dm_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(DM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        dm_err_q, dm_err_d;

  logic acc, mstall, lu, timeout;

  assign acc     = mem_MemRead | mem_MemWrite;
  assign mstall  = acc & ~dm_ready & (state_q != ERROR);
  assign timeout = mstall & (wait_cnt_q == TMO_LAST);
  assign lu      = ex_MemToReg & ex_RegWrite
                 & (ex_writeReg != 5'd0)
                 & ((ex_writeReg == id_rs)
                 | (ex_writeReg == id_rt));

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src
  );
    if (mem_RegWrite && !mem_MemToReg &&
        mem_writeReg != 5'd0 &&
        mem_writeReg == src)
      return 2'b10;
    else if (wb_RegWrite &&
             wb_writeReg != 5'd0 &&
             wb_writeReg == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      dm_err_q    <= dm_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (timeout)     state_d = ERROR;
        else if (mstall) state_d = MEMWAIT;
      end
      MEMWAIT: begin
        if (timeout)      state_d = ERROR;
        else if (!mstall) state_d = RUN;
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
    wait_cnt_d  = mstall ? wait_cnt_q + 8'd1 : 8'd0;
    dm_err_d    = dm_err_q | (state_d == ERROR);
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_comb begin
    dm_req      = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    exmem_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (clr) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q != ERROR) begin
      dm_req = acc;
      fwd_a  = fwd_sel(ex_rs);
      fwd_b  = fwd_sel(ex_rt);
      if (mstall) begin
        memwb_flush = 1'b1;
      end else if (branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu) begin
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end
  end

  assign dm_err    = dm_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the
// combinational decode plus sequences for stalls and timeout.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_writeReg;
  logic        ex_RegWrite, ex_MemToReg;
  logic [4:0]  mem_writeReg;
  logic        mem_RegWrite, mem_MemToReg;
  logic        mem_MemRead, mem_MemWrite;
  logic [4:0]  wb_writeReg;
  logic        wb_RegWrite, branch_taken, dm_ready;
  logic        dm_req, pc_en, ifid_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        dm_err;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DM_TIMEOUT(15)) dut (
    .clk(clk), .clr(clr),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_writeReg(ex_writeReg),
    .ex_RegWrite(ex_RegWrite),
    .ex_MemToReg(ex_MemToReg),
    .mem_writeReg(mem_writeReg),
    .mem_RegWrite(mem_RegWrite),
    .mem_MemToReg(mem_MemToReg),
    .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite),
    .wb_writeReg(wb_writeReg),
    .wb_RegWrite(wb_RegWrite),
    .branch_taken(branch_taken),
    .dm_ready(dm_ready),
    .dm_req(dm_req), .pc_en(pc_en),
    .ifid_en(ifid_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .memwb_flush(memwb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dm_err(dm_err), .stall_cnt(stall_cnt)
  );

  // {dm_req,pc_en,ifid_en,exmem_en,ifid_fl,idex_fl,memwb_fl}
  logic [6:0] ctrl;
  assign ctrl = {dm_req, pc_en, ifid_en, exmem_en,
                 ifid_flush, idex_flush, memwb_flush};

  localparam logic [6:0] C_RUN   = 7'b0111000;
  localparam logic [6:0] C_LU    = 7'b0001010;
  localparam logic [6:0] C_BR    = 7'b0111110;
  localparam logic [6:0] C_MACC  = 7'b1111000;
  localparam logic [6:0] C_MWAIT = 7'b1000001;
  localparam logic [6:0] C_MBR   = 7'b1111110;
  localparam logic [6:0] C_ERR   = 7'b0000000;
  localparam logic [6:0] C_CLR   = 7'b0000111;

  typedef struct {
    string      name;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr;
    logic       ex_rw, ex_m2r;
    logic [4:0] mem_wr;
    logic       mem_rw, mem_m2r, mem_rd, mem_wt;
    logic [4:0] wb_wr;
    logic       wb_rw, br, rdy;
    logic [6:0] exp_ctrl;
    logic [1:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0;
    ex_writeReg = 0; ex_RegWrite = 0; ex_MemToReg = 0;
    mem_writeReg = 0; mem_RegWrite = 0;
    mem_MemToReg = 0; mem_MemRead = 0; mem_MemWrite = 0;
    wb_writeReg = 0; wb_RegWrite = 0;
    branch_taken = 0; dm_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    chk("clr_ctrl", 32'(ctrl), 32'(C_CLR));
    step();
    clr = 1'b0;
    #1;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt;
    ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    ex_writeReg = v.ex_wr;
    ex_RegWrite = v.ex_rw; ex_MemToReg = v.ex_m2r;
    mem_writeReg = v.mem_wr; mem_RegWrite = v.mem_rw;
    mem_MemToReg = v.mem_m2r;
    mem_MemRead = v.mem_rd; mem_MemWrite = v.mem_wt;
    wb_writeReg = v.wb_wr; wb_RegWrite = v.wb_rw;
    branch_taken = v.br; dm_ready = v.rdy;
  endtask

  function automatic vec_t mk(input string nm);
    vec_t v;
    v.name = nm;
    v.id_rs = 0; v.id_rt = 0; v.ex_rs = 0; v.ex_rt = 0;
    v.ex_wr = 0; v.ex_rw = 0; v.ex_m2r = 0;
    v.mem_wr = 0; v.mem_rw = 0; v.mem_m2r = 0;
    v.mem_rd = 0; v.mem_wt = 0;
    v.wb_wr = 0; v.wb_rw = 0; v.br = 0; v.rdy = 1;
    v.exp_ctrl = C_RUN; v.exp_a = 2'b00; v.exp_b = 2'b00;
    return v;
  endfunction

  task automatic build_table();
    vec_t v;
    v = mk("idle"); vecs.push_back(v);
    v = mk("lu_rs"); v.ex_m2r = 1; v.ex_rw = 1;
    v.ex_wr = 5; v.id_rs = 5; v.exp_ctrl = C_LU;
    vecs.push_back(v);
    v = mk("lu_rt"); v.ex_m2r = 1; v.ex_rw = 1;
    v.ex_wr = 9; v.id_rt = 9; v.id_rs = 2;
    v.exp_ctrl = C_LU; vecs.push_back(v);
    v = mk("lu_r0"); v.ex_m2r = 1; v.ex_rw = 1;
    vecs.push_back(v);
    v = mk("alu_no_lu"); v.ex_rw = 1;
    v.ex_wr = 5; v.id_rs = 5; vecs.push_back(v);
    v = mk("br_lu"); v.ex_m2r = 1; v.ex_rw = 1;
    v.ex_wr = 5; v.id_rs = 5; v.br = 1;
    v.exp_ctrl = C_BR; vecs.push_back(v);
    v = mk("fwd_mem"); v.ex_rs = 7; v.mem_wr = 7;
    v.wb_wr = 7; v.mem_rw = 1; v.wb_rw = 1;
    v.exp_a = 2'b10; vecs.push_back(v);
    v = mk("fwd_wb"); v.ex_rs = 7; v.mem_wr = 7;
    v.wb_wr = 7; v.wb_rw = 1; v.exp_a = 2'b01;
    vecs.push_back(v);
    v = mk("fwd_memld"); v.ex_rs = 7; v.mem_wr = 7;
    v.wb_wr = 7; v.mem_rw = 1; v.mem_m2r = 1;
    v.wb_rw = 1; v.exp_a = 2'b01; vecs.push_back(v);
    v = mk("fwd_ab"); v.ex_rs = 4; v.ex_rt = 3;
    v.mem_wr = 3; v.mem_rw = 1; v.wb_wr = 4;
    v.wb_rw = 1; v.exp_a = 2'b01; v.exp_b = 2'b10;
    vecs.push_back(v);
    v = mk("fwd_r0"); v.mem_rw = 1; v.wb_rw = 1;
    vecs.push_back(v);
    v = mk("rd_0wait"); v.mem_rd = 1;
    v.exp_ctrl = C_MACC; vecs.push_back(v);
    v = mk("wr_0wait"); v.mem_wt = 1;
    v.exp_ctrl = C_MACC; vecs.push_back(v);
  endtask

  initial begin
    idle();
    build_table();

    clr = 1'b1;
    ex_rs = 7; mem_writeReg = 7; mem_RegWrite = 1;
    mem_MemRead = 1;
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(C_CLR));
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'(0));
    chk("rst_err", 32'(dm_err), 32'(0));
    chk("rst_scnt", 32'(stall_cnt), 32'(0));
    step();
    clr = 1'b0;
    idle();
    #1;
    chk("run_ctrl", 32'(ctrl), 32'(C_RUN));

    ex_MemToReg = 1; ex_RegWrite = 1;
    ex_writeReg = 5; id_rs = 5;
    #1;
    chk("lu_ctrl", 32'(ctrl), 32'(C_LU));
    step();
    chk("lu_scnt", 32'(stall_cnt), 32'(1));
    idle();
    mem_MemRead = 1; mem_writeReg = 5;
    mem_MemToReg = 1; mem_RegWrite = 1;
    #1;
    chk("lu_after", 32'(ctrl), 32'(C_MACC));
    step();
    chk("lu_scnt2", 32'(stall_cnt), 32'(1));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      chk({vecs[i].name, "_ctrl"}, 32'(ctrl),
          32'(vecs[i].exp_ctrl));
      chk({vecs[i].name, "_fwd"}, 32'({fwd_a, fwd_b}),
          32'({vecs[i].exp_a, vecs[i].exp_b}));
      step();
    end

    idle();
    do_reset();
    mem_MemRead = 1; dm_ready = 0; branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_ctrl%0d", i), 32'(ctrl),
          32'(C_MWAIT));
      step();
    end
    dm_ready = 1;
    #1;
    chk("mw_done", 32'(ctrl), 32'(C_MBR));
    step();
    idle();
    #1;
    chk("mw_run", 32'(ctrl), 32'(C_RUN));
    chk("mw_scnt", 32'(stall_cnt), 32'(3));
    chk("mw_err", 32'(dm_err), 32'(0));

    do_reset();
    mem_MemRead = 1; dm_ready = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("to_ctrl%0d", i), 32'(ctrl),
          32'(C_MWAIT));
      chk($sformatf("to_err%0d", i), 32'(dm_err),
          32'(0));
      step();
    end
    chk("to_err", 32'(dm_err), 32'(1));
    chk("to_ctrl", 32'(ctrl), 32'(C_ERR));
    chk("to_scnt", 32'(stall_cnt), 32'(15));
    dm_ready = 1;
    step();
    step();
    chk("err_hold", 32'(ctrl), 32'(C_ERR));
    chk("err_sticky", 32'(dm_err), 32'(1));
    chk("err_scnt", 32'(stall_cnt), 32'(17));
    do_reset();
    chk("to_rst_err", 32'(dm_err), 32'(0));
    chk("to_rst_scnt", 32'(stall_cnt), 32'(0));
    chk("to_rst_ctrl", 32'(ctrl), 32'(C_MACC));
    idle();
    step();

    mem_MemRead = 1; dm_ready = 0;
    step();
    step();
    #1;
    chk("mid_wait", 32'(ctrl), 32'(C_MWAIT));
    clr = 1'b1;
    #1;
    chk("mid_clr", 32'(ctrl), 32'(C_CLR));
    chk("mid_scnt", 32'(stall_cnt), 32'(0));
    step();
    clr = 1'b0;
    dm_ready = 1;
    #1;
    chk("mid_acc", 32'(ctrl), 32'(C_MACC));
    step();
    idle();
    #1;
    chk("mid_run", 32'(ctrl), 32'(C_RUN));
    chk("mid_scnt2", 32'(stall_cnt), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central sequencing controller for the five-stage pipeline. It decides every cycle whether each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds, or takes a bubble. It resolves three hazard classes:

- load-use stalls,
- taken-branch flushes,
- data-memory wait states, with a timeout watchdog.

It also drives the EX-stage operand forwarding selects from the EX/MEM and MEM/WB register fields.

## Interface
Parameters:
- DM_TIMEOUT, 15: consecutive not-ready memory cycles before the controller enters ERROR (legal range 1..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- ex_rs, ex_rt  in  5 each  source registers of the instruction in EX.
- ex_writeReg  in  5  destination register in EX.
- ex_RegWrite, ex_MemToReg  in  1 each  EX-stage controls.
- mem_writeReg  in  5  destination register in MEM.
- mem_RegWrite, mem_MemToReg  in  1 each  MEM-stage controls.
- mem_MemRead, mem_MemWrite  in  1 each  data-memory access in MEM.
- wb_writeReg  in  5  MEM/WB register bits [6:2].
- wb_RegWrite  in  1  MEM/WB register bit [0].
- branch_taken  in  1  branch resolved taken in EX.
- dm_ready  in  1  data memory completes the access this cycle.
- dm_req  out  1  data-memory request.
- pc_en, ifid_en, exmem_en  out  1 each  load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  synchronous bubble insert.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 WB value, 10 MEM alu_out.
- dm_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  16  count of cycles with pc_en=0, saturating.

## Operation
State machine:
- States: RUN, MEMWAIT, ERROR.
- Registers: state, wait_cnt (8 bit), stall_cnt, dm_err.

Memory access:
- acc = mem_MemRead | mem_MemWrite.
- dm_req = acc in RUN and MEMWAIT; dm_req = 0 in ERROR.

Hazard conditions:
- mstall = acc & ~dm_ready, in RUN or MEMWAIT.
- lu (load-use) = ex_MemToReg & ex_RegWrite & (ex_writeReg != 0) & (ex_writeReg == id_rs | ex_writeReg == id_rt).

Priority, highest first:
- ERROR: all enables 0, all flushes 0. The pipeline is frozen.
- mstall: pc_en = ifid_en = exmem_en = 0, idex_flush = 0, ifid_flush = 0, memwb_flush = 1. EX is frozen, so any branch_taken is held and acted on after the wait.
- branch_taken: all enables 1, ifid_flush = idex_flush = 1. Load-use is ignored because the ID instruction is squashed.
- lu: pc_en = ifid_en = 0, idex_flush = 1, exmem_en = 1.
- Otherwise: all enables 1, all flushes 0.

State transitions:
- RUN→MEMWAIT when mstall.
- MEMWAIT→RUN on the edge where dm_ready = 1.
- MEMWAIT→ERROR when mstall and wait_cnt == DM_TIMEOUT−1.
- ERROR is left only by clr.

wait_cnt:
- Increments on every edge with mstall.
- Cleared on any edge without mstall.
- Holds the number of consecutive not-ready cycles already completed.

dm_err:
- Set on entry to ERROR.
- Held until clr.

stall_cnt:
- Increments on each edge with pc_en = 0.
- Saturates at 16'hFFFF.

Forwarding, evaluated independently for fwd_a (ex_rs) and fwd_b (ex_rt):
- 10 if mem_RegWrite & ~mem_MemToReg & mem_writeReg != 0 & mem_writeReg == src.
- Else 01 if wb_RegWrite & wb_writeReg != 0 & wb_writeReg == src.
- Else 00.
- MEM has priority over WB.
- Forwarding is combinational and is also valid during stalls.

## Timing
- All control outputs are combinational from state and inputs. Pipeline registers sample them at the next rising edge.
- Zero-wait memory (dm_ready = 1 in the request cycle) causes no stall and no state change.
- A one-wait access inserts exactly 1 stall cycle: RUN→MEMWAIT→RUN.
- A load-use hazard costs exactly one bubble. On the next cycle the load sits in MEM, so lu is false.

Reset, asynchronous:
- state = RUN, wait_cnt = 0, stall_cnt = 0, dm_err = 0.
- While clr = 1, outputs are forced: dm_req = 0, pc_en = ifid_en = exmem_en = 0, all flushes = 1, fwd_a = fwd_b = 00.
- clr asserted mid-MEMWAIT abandons the access. No dm_req is issued in the clr cycle.

Boundary cases:
- Simultaneous branch_taken and mstall: the stall wins and the flush happens on the cycle dm_ready returns.
- DM_TIMEOUT = 1: the first not-ready cycle leads to ERROR at the next edge.

## Test plan
- **Load-use:** load with ex_writeReg = 5, id_rs = 5 → one cycle of pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cnt goes 0→1; the next cycle is all enables 1.
- **Register 0 and forwarding:**
  - ex_writeReg = 0 with a load → no stall.
  - mem_writeReg = wb_writeReg = 7 = ex_rs, both RegWrite → fwd_a = 10.
  - Drop mem_RegWrite → fwd_a = 01.
- **Branch:** branch_taken = 1 alongside lu → ifid_flush = idex_flush = 1, pc_en = 1, no stall counted.
- **Memory wait:** mem_MemRead = 1, dm_ready low for 3 cycles → dm_req = 1 throughout; pc_en = 0 and memwb_flush = 1 for 3 cycles; back to RUN after dm_ready; stall_cnt = 3.
- **Timeout:** dm_ready held 0 with DM_TIMEOUT = 15 → dm_err rises after 15 stalled cycles; dm_req = 0 and all enables 0 after that; clr restores RUN with dm_err = 0 and stall_cnt = 0.
- **Reset mid-wait:** assert clr in MEMWAIT → all outputs immediately take their reset values; after release, an access with dm_ready = 1 completes with no stall.
